mc_system: RTL and testbench

//  Parametrised multicycle successor of the single-cycle MIPS system top: one shared memory bus

---
 rtl/mc_system_if.sv | 31 +++
 rtl/mc_system.sv | 236 +++++++++++++++++++++++
 tb/tb_mc_system.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_system_if.sv
// Shared memory bus for mc_system. The DUT is the master and a memory model is the slave.
// A transfer completes on the rising edge where mem_req && mem_ack.
interface mc_system_if #(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [PC_W-1:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mc_system.sv
// Multicycle MIPS-subset system: shared req/ack memory bus, FSM-sequenced datapath, precise
// exceptions (EPC/CAUSE), retired counter and LED debug mux. Define MC_ERET_EN to decode ERET.
module mc_system #(
    parameter int unsigned     PC_W    = 8,
    parameter int unsigned     DATA_W  = 32,
    parameter int unsigned     LED_W   = 27,
    parameter logic [PC_W-1:0] EXC_VEC = 8'h80
) (
    input  logic             SYS_clk,
    input  logic             SYS_reset,
    input  logic             SYS_load,
    input  logic [PC_W-1:0]  SYS_pc_val,
    input  logic [7:0]       SYS_output_sel,
    output logic [LED_W-1:0] SYS_leds,
    mc_system_if.master      bus
);
    localparam int unsigned     Msb    = DATA_W - 1;
    localparam logic [PC_W-1:0] PcStep = PC_W'(4);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnAnd   = 6'h24;
    localparam logic [5:0] FnOr    = 6'h25;
    localparam logic [5:0] FnSlt   = 6'h2a;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StExc    = 3'd5
    } state_e;

    state_e            state_q;
    logic [PC_W-1:0]   pc_q, epc_q;
    logic [1:0]        cause_q;
    logic [DATA_W-1:0] ir_q, a_q, b_q, alu_out_q, mdr_q;
    logic [15:0]       retired_q;
    logic              zero_q, ovf_q, neg_q;
    logic [DATA_W-1:0] rf_q [32];

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd, wb_dst;
    logic [DATA_W-1:0] imm_sext, wb_data;
    logic              is_rtype_alu, is_eret, legal;
    logic              req;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};

    always_comb begin
        is_rtype_alu = (opcode == OpRtype) && (funct inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt});
`ifdef MC_ERET_EN
        is_eret = (opcode == 6'h10) && (funct == 6'h18);
`else
        is_eret = 1'b0;
`endif
        legal = is_rtype_alu || is_eret || (opcode inside {OpJ, OpBeq, OpAddi, OpLw, OpSw});
    end

    // ALU for R-type and addi; overflow only matters for add/sub/addi
    logic [DATA_W-1:0] alu_b, alu_res;
    logic              alu_ovf, ovf_chk, is_sub;

    always_comb begin
        alu_b   = (opcode == OpRtype) ? b_q : imm_sext;
        is_sub  = (opcode == OpRtype) && (funct == FnSub);
        ovf_chk = (opcode == OpAddi) || ((opcode == OpRtype) && (funct inside {FnAdd, FnSub}));
        alu_res = a_q + alu_b;
        if (opcode == OpRtype) begin
            case (funct)
                FnSub:   alu_res = a_q - b_q;
                FnAnd:   alu_res = a_q & b_q;
                FnOr:    alu_res = a_q | b_q;
                FnSlt:   alu_res = DATA_W'($signed(a_q) < $signed(b_q));
                default: ;
            endcase
        end
        if (is_sub) begin
            alu_ovf = (a_q[Msb] != b_q[Msb]) && (alu_res[Msb] != a_q[Msb]);
        end else begin
            alu_ovf = (a_q[Msb] == alu_b[Msb]) && (alu_res[Msb] != a_q[Msb]);
        end
        alu_ovf = alu_ovf && ovf_chk;
    end

    // Bus request drops combinationally with reset so an aborted transfer never completes
    assign req           = ((state_q == StFetch) || (state_q == StMem)) && !SYS_load && !SYS_reset;
    assign bus.mem_req   = req;
    assign bus.mem_we    = (state_q == StMem) && (opcode == OpSw);
    assign bus.mem_addr  = (state_q == StMem) ? alu_out_q[PC_W-1:0] : pc_q;
    assign bus.mem_wdata = b_q;

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            epc_q     <= '0;
            cause_q   <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            retired_q <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (SYS_load) begin
                        pc_q <= SYS_pc_val;
                    end else if (bus.mem_ack) begin
                        ir_q    <= bus.mem_rdata;
                        pc_q    <= pc_q + PcStep;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    a_q       <= rf_q[rs];
                    b_q       <= rf_q[rt];
                    alu_out_q <= {{(DATA_W-PC_W){1'b0}}, pc_q} + (imm_sext << 2);
                    if (legal) begin
                        state_q <= StExec;
                    end else begin
                        cause_q <= 2'd1;
                        state_q <= StExc;
                    end
                end
                StExec: begin
                    if (is_eret) begin
                        pc_q      <= epc_q;
                        retired_q <= retired_q + 16'd1;
                        state_q   <= StFetch;
                    end else begin
                        case (opcode)
                            OpBeq: begin
                                if (a_q == b_q) pc_q <= alu_out_q[PC_W-1:0];
                                retired_q <= retired_q + 16'd1;
                                state_q   <= StFetch;
                            end
                            OpJ: begin
                                // Region bits of the old PC fall off the top at this PC width
                                pc_q      <= {ir_q[PC_W-3:0], 2'b00};
                                retired_q <= retired_q + 16'd1;
                                state_q   <= StFetch;
                            end
                            OpLw, OpSw: begin
                                alu_out_q <= a_q + imm_sext;
                                state_q   <= StMem;
                            end
                            default: begin
                                alu_out_q <= alu_res;
                                zero_q    <= (alu_res == '0);
                                ovf_q     <= alu_ovf;
                                neg_q     <= alu_res[Msb];
                                if (alu_ovf) begin
                                    cause_q <= 2'd2;
                                    state_q <= StExc;
                                end else begin
                                    state_q <= StWb;
                                end
                            end
                        endcase
                    end
                end
                StMem: begin
                    if (req && bus.mem_ack) begin
                        if (opcode == OpLw) begin
                            mdr_q   <= bus.mem_rdata;
                            state_q <= StWb;
                        end else begin
                            retired_q <= retired_q + 16'd1;
                            state_q   <= StFetch;
                        end
                    end
                end
                StWb: begin
                    retired_q <= retired_q + 16'd1;
                    state_q   <= StFetch;
                end
                StExc: begin
                    epc_q   <= pc_q - PcStep;
                    pc_q    <= EXC_VEC;
                    state_q <= StFetch;
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    assign wb_dst  = (opcode == OpRtype) ? rd : rt;
    assign wb_data = (opcode == OpLw) ? mdr_q : alu_out_q;

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if ((state_q == StWb) && (wb_dst != 5'd0)) begin
            rf_q[wb_dst] <= wb_data;
        end
    end

    logic [DATA_W-1:0] led_val;

    always_comb begin
        led_val = '0;
        case (SYS_output_sel)
            8'd0:    led_val = ir_q;
            8'd1:    led_val = a_q;
            8'd2:    led_val = alu_out_q;
            8'd3:    led_val = DATA_W'({zero_q, ovf_q, neg_q});
            8'd4:    led_val = mdr_q;
            8'd5:    led_val = DATA_W'({cause_q, state_q});
            8'd6:    led_val = DATA_W'(retired_q);
            8'd7:    led_val = DATA_W'({pc_q, epc_q});
            default: ;
        endcase
    end

    assign SYS_leds = SYS_reset ? '0 : led_val[LED_W-1:0];

    logic unused_bits;
    assign unused_bits = ^{ir_q[10:6], led_val[DATA_W-1:LED_W]};
endmodule

// File: tb/tb_mc_system.sv
// Directed bench for mc_system: a fixed program observed through the LED debug mux at known
// cycle counts, plus sequences for wait states, PC load and reset during a store.
module tb_mc_system;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LED_W  = 27;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             load   = 1'b0;
    logic [PC_W-1:0]  pc_val = '0;
    logic [7:0]       sel    = '0;
    logic [LED_W-1:0] leds;

    mc_system_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

    mc_system #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .LED_W  (LED_W),
        .EXC_VEC(8'h80)
    ) dut (
        .SYS_clk       (clk),
        .SYS_reset     (rst),
        .SYS_load      (load),
        .SYS_pc_val    (pc_val),
        .SYS_output_sel(sel),
        .SYS_leds      (leds),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Program image, word-indexed (byte address = 4 * index)
    function automatic logic [31:0] prog_word(input int i);
        case (i)
            0:              return itype(6'h08, 0, 1, 16'd5);     // addi r1,r0,5
            1:              return rtype(1, 1, 2, 6'h20);         // add  r2,r1,r1
            2:              return rtype(1, 2, 3, 6'h22);         // sub  r3,r1,r2
            3:              return rtype(1, 2, 4, 6'h25);         // or   r4,r1,r2
            4:              return rtype(3, 1, 5, 6'h2a);         // slt  r5,r3,r1
            5:              return itype(6'h23, 0, 6, 16'h0060);  // lw   r6,0x60(r0)
            6:              return itype(6'h2b, 0, 6, 16'h0064);  // sw   r6,0x64(r0)
            7:              return itype(6'h23, 0, 9, 16'h0068);  // lw   r9,0x68(r0)
            8:              return itype(6'h04, 0, 0, 16'd2);     // beq  r0,r0,+2
            9, 10, 12, 13:  return itype(6'h08, 0, 7, 16'd1);     // skipped
            11:             return {6'h02, 26'h000000e};          // j    0x38
            14:             return itype(6'h08, 9, 10, 16'd1);    // addi r10,r9,1 overflows
            24:             return 32'hdeadbeef;
            26:             return 32'h7fffffff;
            32:             return 32'h42000018;                  // eret
            default:        return 32'h0;
        endcase
    endfunction

    logic [31:0]     mem [64];
    int              ack_delay = 0;
    int              wait_cnt  = 0;
    int              wr_cnt    = 0;
    logic [PC_W-1:0] wr_addr   = '0;
    logic [31:0]     wr_data   = '0;

    assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= prog_word(i);
            wait_cnt <= 0;
        end else if (bus.mem_req && bus.mem_ack) begin
            wait_cnt <= 0;
            if (bus.mem_we) begin
                mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= bus.mem_addr;
                wr_data <= bus.mem_wdata;
            end
        end else if (bus.mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic peek(input logic [7:0] s, output logic [31:0] v);
        sel = s;
        #1;
        v = 32'(leds);
    endtask

    task automatic do_reset(input int delay);
        ack_delay = delay;
        load      = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0]  n;
        logic [7:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int n, input int s, input logic [31:0] e);
        vec_t v;
        v.n   = 8'(n);
        v.sel = 8'(s);
        v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        int          cyc;
        logic [31:0] v;
        int          wr_base;

        // {cycles after reset, led select, expected 27-bit led value}
        add_vec(0, 5, 32'h0);
        add_vec(0, 7, 32'h0);
        add_vec(0, 6, 32'h0);
        add_vec(1, 0, 32'h0010005);
        add_vec(1, 7, 32'h0400);
        add_vec(3, 2, 32'd5);
        add_vec(3, 5, 32'h04);
        add_vec(7, 2, 32'd10);
        add_vec(8, 6, 32'd2);
        add_vec(8, 5, 32'h00);
        add_vec(10, 1, 32'd5);
        add_vec(11, 2, 32'h7fffffb);
        add_vec(11, 3, 32'h1);
        add_vec(15, 2, 32'd15);
        add_vec(15, 3, 32'h0);
        add_vec(19, 2, 32'd1);
        add_vec(23, 2, 32'h60);
        add_vec(23, 5, 32'h03);
        add_vec(24, 4, 32'h6adbeef);
        add_vec(29, 6, 32'd7);
        add_vec(33, 4, 32'h7ffffff);
        add_vec(36, 2, 32'h2c);
        add_vec(37, 7, 32'h2c00);
        add_vec(37, 6, 32'd9);
        add_vec(40, 7, 32'h3800);
        add_vec(40, 6, 32'd10);
        add_vec(42, 1, 32'h7ffffff);
        add_vec(43, 5, 32'h15);
        add_vec(43, 3, 32'h3);
        add_vec(44, 7, 32'h8038);
        add_vec(44, 6, 32'd10);
        add_vec(44, 5, 32'h10);
`ifdef MC_ERET_EN
        add_vec(47, 7, 32'h3838);
        add_vec(47, 5, 32'h10);
        add_vec(47, 6, 32'd11);
`else
        add_vec(47, 7, 32'h8080);
        add_vec(47, 5, 32'h08);
        add_vec(47, 6, 32'd10);
`endif

        // Program run with zero-wait memory
        do_reset(0);
        cyc = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < int'(vecs[i].n)) begin
                @(posedge clk);
                cyc++;
                #2;
            end
            peek(vecs[i].sel, v);
            check($sformatf("vec%0d_n%0d_sel%0d", i, vecs[i].n, vecs[i].sel), v, vecs[i].exp);
        end
        check("sw_count", 32'(wr_cnt), 32'd1);
        check("sw_addr", 32'(wr_addr), 32'h64);
        check("sw_data", wr_data, 32'hdeadbeef);
        check("sw_mem", mem[25], 32'hdeadbeef);

        // Fetch with three wait states: request held, PC advanced exactly once
        do_reset(3);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #2;
            check($sformatf("wait%0d_req_addr", k), {23'b0, bus.mem_req, bus.mem_addr}, 32'h100);
            check($sformatf("wait%0d_ack", k), 32'(bus.mem_ack), 32'(k == 3));
        end
        @(posedge clk);
        #2;
        peek(8'd7, v);
        check("wait_pc_after_ack", v, 32'h0400);
        peek(8'd0, v);
        check("wait_ir", v, 32'h0010005);
        @(posedge clk);
        #2;
        peek(8'd7, v);
        check("wait_pc_once", v, 32'h0400);

        // PC load in FETCH
        do_reset(0);
        load   = 1'b1;
        pc_val = 8'h40;
        #1;
        check("load_req_low", 32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #2;
        peek(8'd7, v);
        check("load_pc", v, 32'h4000);
        load = 1'b0;
        #1;
        check("load_fetch_addr", {23'b0, bus.mem_req, bus.mem_addr}, 32'h140);
        @(posedge clk);
        #2;
        peek(8'd7, v);
        check("load_pc_incr", v, 32'h4400);

        // Asynchronous reset while the store waits in MEM
        do_reset(0);
        cyc = 0;
        while (cyc < 28) begin
            @(posedge clk);
            cyc++;
            #2;
        end
        ack_delay = 100;
        peek(8'd5, v);
        check("mid_mem_state", v, 32'h03);
        check("mid_mem_we_addr", {23'b0, bus.mem_we, bus.mem_addr}, 32'h164);
        peek(8'd6, v);
        check("mid_mem_retired", v, 32'd6);
        wr_base = wr_cnt;
        rst = 1'b1;
        #1;
        check("rst_req_drop", 32'(bus.mem_req), 32'd0);
        check("rst_leds_zero", 32'(leds), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        peek(8'd7, v);
        check("rst_pc_epc", v, 32'h0);
        peek(8'd6, v);
        check("rst_retired", v, 32'h0);
        peek(8'd2, v);
        check("rst_aluout", v, 32'h0);
        peek(8'd4, v);
        check("rst_mdr", v, 32'h0);
        peek(8'd1, v);
        check("rst_a", v, 32'h0);
        check("rst_no_store", 32'(wr_cnt), 32'(wr_base));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
